time_controller: RTL and testbench



---
 rtl/tc_pkg.sv | 26 ++
 rtl/tc_trig_sync.sv | 38 +++
 rtl/time_controller.sv | 140 ++++++++++++++
 tb/tb_time_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared types and default widths for the real-time timebase controller.
package tc_pkg;

  localparam int TC_CNT_W       = 64;
  localparam int TC_DELAY_W     = 32;
  localparam int TC_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_LOAD     = 3'd1,
    OP_START    = 3'd2,
    OP_ARM      = 3'd3,
    OP_ARM_TRIG = 3'd4,
    OP_STOP     = 3'd5,
    OP_CLEAR    = 3'd6,
    OP_RESERVED = 3'd7
  } tc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_WAIT_TRIG = 2'd2,
    ST_RUNNING   = 2'd3
  } tc_state_e;

endpackage

// File: rtl/tc_trig_sync.sv
// Synchronizes the asynchronous external trigger and emits a registered
// one-cycle pulse on each rising edge of the synchronized level.
module tc_trig_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ext_trig,
  output logic trig_rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   last_q, last_d;
  logic                   rise_q, rise_d;

  // Shift the raw trigger through the chain; edge = new level high, old low.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ext_trig};
    last_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~last_q;
  end

  // Synchronizer, history and edge-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
      rise_q <= rise_d;
    end
  end

  assign trig_rise = rise_q;

endmodule

// File: rtl/time_controller.sv
// Global timebase: 64-bit run counter plus one-cycle auto_start strobe,
// controlled by a valid/ready command port and an external trigger.
module time_controller
  import tc_pkg::*;
#(
  parameter int CNT_WIDTH   = TC_CNT_W,
  parameter int DELAY_WIDTH = TC_DELAY_W,
  parameter int SYNC_STAGES = TC_SYNC_STAGES
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_aresetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [CNT_WIDTH-1:0] cmd_data,
  input  logic                 ext_trig,
  output logic [CNT_WIDTH-1:0] counter,
  output logic                 auto_start,
  output logic                 running,
  output logic [1:0]           state,
  output logic                 cmd_error,
  output logic                 wrapped
);

  tc_state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0]   counter_q, counter_d;
  logic [DELAY_WIDTH-1:0] delay_q, delay_d;
  logic                   wrapped_q, wrapped_d;
  logic                   auto_start_q, auto_start_d;
  logic                   cmd_error_q, cmd_error_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   trig_rise;
  logic                   cmd_owns_fsm;
  tc_op_e                 op;

  tc_trig_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_trig_sync (
    .clk       (s_axi_aclk),
    .rst_n     (s_axi_aresetn),
    .ext_trig  (ext_trig),
    .trig_rise (trig_rise)
  );

  // Only an accepted command is decoded; otherwise it reads as NOP.
  assign op = (cmd_valid && cmd_ready_q) ? tc_op_e'(cmd_op) : OP_NOP;

  // Command decode, counting, delay countdown and FSM next state.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    delay_d      = delay_q;
    wrapped_d    = wrapped_q;
    cmd_error_d  = 1'b0;
    cmd_ready_d  = 1'b1;
    cmd_owns_fsm = 1'b0;

    if (state_q == ST_RUNNING) begin
      counter_d = counter_q + CNT_WIDTH'(1);
      if (&counter_q) wrapped_d = 1'b1;
    end
    if (state_q == ST_ARMED) delay_d = delay_q - DELAY_WIDTH'(1);

    case (op)
      OP_LOAD: begin
        if (state_q == ST_IDLE) counter_d = cmd_data;
        else cmd_error_d = 1'b1;
      end
      OP_START: begin
        if (state_q == ST_IDLE) state_d = ST_RUNNING;
        else cmd_error_d = 1'b1;
      end
      OP_ARM: begin
        if (state_q == ST_IDLE) begin
          delay_d = cmd_data[DELAY_WIDTH-1:0];
          // Zero delay collapses to an immediate start.
          state_d = (cmd_data[DELAY_WIDTH-1:0] == '0) ? ST_RUNNING : ST_ARMED;
        end else begin
          cmd_error_d = 1'b1;
        end
      end
      OP_ARM_TRIG: begin
        if (state_q == ST_IDLE) state_d = ST_WAIT_TRIG;
        else cmd_error_d = 1'b1;
      end
      OP_STOP: begin
        state_d      = ST_IDLE;
        counter_d    = counter_q;
        wrapped_d    = wrapped_q;
        cmd_owns_fsm = 1'b1;
      end
      OP_CLEAR: begin
        state_d      = ST_IDLE;
        counter_d    = '0;
        wrapped_d    = 1'b0;
        cmd_owns_fsm = 1'b1;
      end
      OP_RESERVED: cmd_error_d = 1'b1;
      default: ;
    endcase

    // STOP/CLEAR beat a same-cycle delay expiry or trigger edge.
    if (!cmd_owns_fsm) begin
      if (state_q == ST_ARMED && delay_q == DELAY_WIDTH'(1)) state_d = ST_RUNNING;
      if (state_q == ST_WAIT_TRIG && trig_rise) state_d = ST_RUNNING;
    end

    auto_start_d = (state_d == ST_RUNNING) && (state_q != ST_RUNNING);
  end

  // State and output registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= ST_IDLE;
      counter_q    <= '0;
      delay_q      <= '0;
      wrapped_q    <= 1'b0;
      auto_start_q <= 1'b0;
      cmd_error_q  <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      delay_q      <= delay_d;
      wrapped_q    <= wrapped_d;
      auto_start_q <= auto_start_d;
      cmd_error_q  <= cmd_error_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign counter    = counter_q;
  assign auto_start = auto_start_q;
  assign running    = (state_q == ST_RUNNING);
  assign state      = state_q;
  assign cmd_error  = cmd_error_q;
  assign wrapped    = wrapped_q;

endmodule

// File: tb/tb_time_controller.sv
// Bench for time_controller: directed steps from the test plan followed by
// random commands/triggers, all checked against a cycle-indexed model.
module tb_time_controller;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [63:0] cmd_data;
  logic        ext_trig;
  logic [63:0] counter;
  logic        auto_start;
  logic        running;
  logic [1:0]  state;
  logic        cmd_error;
  logic        wrapped;

  int tests = 0;
  int fails = 0;

  time_controller #(.CNT_WIDTH(64), .DELAY_WIDTH(32), .SYNC_STAGES(SYNC)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .ext_trig      (ext_trig),
    .counter       (counter),
    .auto_start    (auto_start),
    .running       (running),
    .state         (state),
    .cmd_error     (cmd_error),
    .wrapped       (wrapped)
  );

  always #5 clk = ~clk;

  // Model: expected outputs for the current cycle; cycles counted from reset.
  int          m_st;
  logic [63:0] m_cnt;
  bit          m_wr, m_auto, m_err, m_ready;
  longint      deadline;
  bit          hist[$];

  function automatic bit hist_at(int i);
    return (i < 0) ? 1'b0 : hist[i];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all();
    chk("counter", counter, m_cnt);
    chk("state", 64'(state), 64'(m_st));
    chk("running", 64'(running), 64'(m_st == 3));
    chk("auto_start", 64'(auto_start), 64'(m_auto));
    chk("cmd_error", 64'(cmd_error), 64'(m_err));
    chk("wrapped", 64'(wrapped), 64'(m_wr));
    chk("cmd_ready", 64'(cmd_ready), 64'(m_ready));
  endtask

  // One clock cycle: drive inputs, predict next cycle, advance, compare.
  task automatic step(input bit v, input logic [2:0] op, input logic [63:0] d, input bit trig);
    int          n, nst;
    bit          rise, acc, nerr, owns, nwr;
    logic [63:0] ncnt;
    cmd_valid = v; cmd_op = op; cmd_data = d; ext_trig = trig;
    n    = hist.size();
    rise = hist_at(n - SYNC - 1) && !hist_at(n - SYNC - 2);
    hist.push_back(trig);
    acc  = v && m_ready;
    nst = m_st; ncnt = m_cnt; nwr = m_wr; nerr = 0; owns = 0;
    if (m_st == 3) begin
      ncnt = m_cnt + 64'd1;
      if (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF) nwr = 1;
    end
    if (acc) begin
      case (op)
        3'd1: if (m_st == 0) ncnt = d; else nerr = 1;
        3'd2: if (m_st == 0) nst = 3; else nerr = 1;
        3'd3: if (m_st == 0) begin
                if (d[31:0] == 32'd0) nst = 3;
                else begin nst = 1; deadline = longint'(n) + 1 + longint'(d[31:0]); end
              end else nerr = 1;
        3'd4: if (m_st == 0) nst = 2; else nerr = 1;
        3'd5: begin nst = 0; ncnt = m_cnt; nwr = m_wr; owns = 1; end
        3'd6: begin nst = 0; ncnt = 64'd0; nwr = 0; owns = 1; end
        3'd7: nerr = 1;
        default: ;
      endcase
    end
    if (!owns) begin
      if (m_st == 1 && longint'(n) + 1 == deadline) nst = 3;
      if (m_st == 2 && rise) nst = 3;
    end
    @(posedge clk); #1;
    m_auto = (nst == 3) && (m_st != 3);
    m_st = nst; m_cnt = ncnt; m_wr = nwr; m_err = nerr; m_ready = 1;
    chk_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 3'd0, 64'd0, 0);
  endtask

  // Assert reset (asynchronously), check cleared outputs, release on a negedge.
  task automatic do_reset(input bit first);
    cmd_valid = 0; cmd_op = 3'd0; cmd_data = 64'd0; ext_trig = 0;
    rst_n = 0;
    #1;
    if (first) begin repeat (2) @(posedge clk); #1; end
    chk("rst_counter", counter, 64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_auto", 64'(auto_start), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_err", 64'(cmd_error), 64'd0);
    chk("rst_wrapped", 64'(wrapped), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    rst_n = 1;
    m_st = 0; m_cnt = 64'd0; m_wr = 0; m_auto = 0; m_err = 0; m_ready = 0;
    deadline = -1;
    hist.delete();
  endtask

  initial begin
    bit          v, trig;
    logic [2:0]  op;
    logic [63:0] d;

    do_reset(1);
    idle(2);

    // LOAD then START; count check ten cycles on.
    step(1, 3'd1, 64'h100, 0);
    step(1, 3'd2, 64'd0, 0);
    chk("start_auto", 64'(auto_start), 64'd1);
    chk("start_cnt", counter, 64'h100);
    idle(10);
    chk("cnt_10a", counter, 64'h10A);
    chk("cnt_running", 64'(running), 64'd1);

    // ARM with delay 5: ARMED for five cycles, then start.
    step(1, 3'd5, 64'd0, 0);
    step(1, 3'd3, 64'd5, 0);
    chk("armed_first", 64'(state), 64'd1);
    idle(4);
    chk("armed_last", 64'(state), 64'd1);
    chk("armed_no_auto", 64'(auto_start), 64'd0);
    idle(1);
    chk("arm_auto", 64'(auto_start), 64'd1);
    idle(2);

    // Wrap-around and CLEAR.
    step(1, 3'd6, 64'd0, 0);
    step(1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    step(1, 3'd2, 64'd0, 0);
    chk("wrap_fe", counter, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(1);
    chk("wrap_ff", counter, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_not_yet", 64'(wrapped), 64'd0);
    idle(1);
    chk("wrap_zero", counter, 64'd0);
    chk("wrap_flag", 64'(wrapped), 64'd1);
    idle(1);
    chk("wrap_one", counter, 64'd1);
    step(1, 3'd6, 64'd0, 0);
    chk("clear_cnt", counter, 64'd0);
    chk("clear_wr", 64'(wrapped), 64'd0);
    chk("clear_state", 64'(state), 64'd0);

    // ARM_TRIG with a 3-cycle trigger pulse; a second pulse does nothing.
    step(1, 3'd4, 64'd0, 0);
    idle(2);
    step(0, 3'd0, 64'd0, 1);
    step(0, 3'd0, 64'd0, 1);
    step(0, 3'd0, 64'd0, 1);
    chk("trig_wait", 64'(state), 64'd2);
    step(0, 3'd0, 64'd0, 0);
    chk("trig_auto", 64'(auto_start), 64'd1);
    idle(6);
    for (int i = 0; i < 3; i++) step(0, 3'd0, 64'd0, 1);
    idle(8);
    chk("trig2_running", 64'(running), 64'd1);

    // Illegal commands while RUNNING.
    step(1, 3'd1, 64'h5555, 0);
    chk("load_err", 64'(cmd_error), 64'd1);
    idle(1);
    chk("err_pulse", 64'(cmd_error), 64'd0);
    step(1, 3'd2, 64'd0, 0);
    chk("start_err", 64'(cmd_error), 64'd1);

    // STOP on the cycle an ARM delay expires.
    step(1, 3'd5, 64'd0, 0);
    step(1, 3'd3, 64'd3, 0);
    idle(2);
    step(1, 3'd5, 64'd0, 0);
    chk("stopwin_state", 64'(state), 64'd0);
    chk("stopwin_auto", 64'(auto_start), 64'd0);
    idle(2);

    // Reserved opcode, then ARM with zero delay (upper bits ignored).
    step(1, 3'd7, 64'd0, 0);
    chk("rsvd_err", 64'(cmd_error), 64'd1);
    step(1, 3'd3, 64'hDEAD_0000_0000, 0);
    chk("arm0_auto", 64'(auto_start), 64'd1);
    idle(5);

    // Reset mid-count.
    do_reset(0);
    idle(4);
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);

    // Random commands and trigger activity.
    trig = 0;
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(0, 99) < 30);
      op = 3'($urandom_range(0, 7));
      d  = {$urandom, $urandom};
      if (op == 3'd3) d[31:0] = 32'($urandom_range(0, 6));
      if (op == 3'd1 && $urandom_range(0, 1) == 1)
        d = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) trig = ~trig;
      step(v, op, d, trig);
      if (i % 1000 == 999) do_reset(0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
